window_readout_ctrl: RTL and testbench
======================================

// Module: window_readout_ctrl
// PURPOSE
//  Sequences the frequency-bin counter datapath in fixed collection windows.
//  - Runs a COLLECT/LATCH window timer and pulses clear to the bin counters.
//  - Snapshots all bin counts at each window end.
//  - Streams the snapshot, one bin per transfer, to one downstream consumer
//    over a valid/ready handshake while the next window collects.
//  - Flags windows lost because the previous readout had not finished.
// PARAMETERS
//  NUM_BINS       8          number of bin counters (>=2)
//  CNT_W          16         width of each bin count
//  WINDOW_CYCLES  4_800_000  COLLECT length in clk cycles (100 ms @ 48 MHz), >=2
//  TIMER_W        26         window timer width; must hold WINDOW_CYCLES-1
// PORTS
//  clk           in   1                 system clock, 48 MHz
//  reset         in   1                 asynchronous, active-high
//  enable        in   1                 run windows when high
//  bin_counts    in   NUM_BINS*CNT_W    live counts; bin i = [i*CNT_W +: CNT_W]
//  clear_counts  out  1                 bin counters clear on next clk edge
//  collecting    out  1                 high during COLLECT (counter gate)
//  out_valid     out  1                 readout word valid
//  out_ready     in   1                 consumer accepts word
//  out_idx       out  $clog2(NUM_BINS)  bin index of out_data
//  out_data      out  CNT_W             snapshot count of bin out_idx
//  out_last      out  1                 high with out_valid on bin NUM_BINS-1
//  overrun       out  1                 sticky: a window snapshot was dropped
// BEHAVIOUR
//  Reset state
//  - Window FSM = IDLE, timer = 0, readout idle, snapshot = 0.
//  - Outputs: clear_counts=1 (IDLE), collecting=0, out_valid=0, out_idx=0,
//    out_data=0, out_last=0, overrun=0.
//  Window FSM (states IDLE, COLLECT, LATCH)
//  - IDLE: clear_counts=1, timer=0. enable=1 -> COLLECT next cycle.
//  - COLLECT: collecting=1, timer increments by 1 each cycle.
//    - timer==WINDOW_CYCLES-1 -> LATCH next cycle.
//    - enable=0 -> IDLE next cycle; partial window discarded, no snapshot.
//  - LATCH: exactly one cycle; clear_counts=1, collecting=0, timer<=0.
//    - Snapshot bin_counts when readout is idle or completing this cycle.
//    - Next state COLLECT if enable=1, else IDLE.
//  - Window period = WINDOW_CYCLES+1 cycles (COLLECT + 1 LATCH).
//  Readout
//  - Begins the cycle after a LATCH that took a snapshot: out_valid=1,
//    out_idx=0, out_data=snapshot[0].
//  - Transfer occurs on valid&&ready; out_idx increments on each transfer.
//  - While valid&&!ready: out_idx and out_data hold stable.
//  - out_last = out_valid && (out_idx==NUM_BINS-1).
//  - After the last transfer: out_valid=0 and out_idx=0 the next cycle.
//  - With ready held high, one word per cycle; NUM_BINS cycles per frame.
//  - out_data comes from snapshot registers only; live counts never appear.
//  Boundaries
//  - LATCH while readout is busy (not on its last transfer):
//    - snapshot is not overwritten and current frame continues unchanged;
//    - overrun set (sticky until reset).
//    - clear_counts still pulses; that window's data is lost.
//  - LATCH in the same cycle as the final transfer: not an overrun. Snapshot
//    is taken and the new frame starts the next cycle (out_valid stays 1,
//    out_idx=0).
//  - enable falling mid-readout: readout completes normally.
//  - Reset mid-operation: all state returns to reset values immediately;
//    a partial frame is abandoned.
// TESTING (WINDOW_CYCLES=10, NUM_BINS=4, CNT_W=16)
//  - Reset release, enable=1 at cycle 0:
//    - collecting high 10 cycles, then LATCH;
//    - clear_counts pulses every 11 cycles.
//  - bin_counts={40,30,20,10} at LATCH, ready=1:
//    - 4 words idx 0..3, data 10,20,30,40;
//    - out_last only on idx 3.
//  - Backpressure: ready=0 for 5 cycles on idx 1 ->
//    idx/data hold at 1/20; completes after ready rises.
//  - ready=0 across the next LATCH -> overrun=1; frame in progress still
//    outputs the old snapshot values.
//  - Final transfer coincides with LATCH -> overrun stays 0; new frame
//    idx 0 the next cycle with new values.
//  - enable=0 at timer=5 -> IDLE with no LATCH and no readout; reset
//    asserted mid-frame -> out_valid=0 immediately.

Source files
------------

// File: rtl/window_readout_ctrl_if.sv
// Readout stream between the window controller and its single consumer.
// One bin count per transfer on valid && ready; last marks the final bin.
interface window_readout_ctrl_if #(
  parameter int NUM_BINS = 8,
  parameter int CNT_W    = 16
) ();
  localparam int IDX_W = $clog2(NUM_BINS);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] out_data;
  logic             out_last;

  // Producer side: the window controller
  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  // Consumer side
  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/window_readout_ctrl.sv
// Window sequencer for the frequency-bin counters.
// Runs fixed COLLECT windows separated by a one-cycle LATCH, clears the bin
// counters, snapshots their counts at each window end and streams the
// snapshot out one bin per transfer while the next window collects.
module window_readout_ctrl #(
  parameter int NUM_BINS      = 8,
  parameter int CNT_W         = 16,
  parameter int WINDOW_CYCLES = 4_800_000,
  parameter int TIMER_W       = 26
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_BINS*CNT_W-1:0] bin_counts,
  output logic                      clear_counts,
  output logic                      collecting,
  output logic                      overrun,
  window_readout_ctrl_if.master     rd
);

  localparam int IDX_W = $clog2(NUM_BINS);
  localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LATCH   = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [TIMER_W-1:0] timer_reg;
  logic [TIMER_W-1:0] timer_next;

  logic               busy_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               overrun_reg;
  logic [CNT_W-1:0]   snap_reg [NUM_BINS];

  logic               xfer;
  logic               last_xfer;
  logic               take_snap;
  logic               drop_snap;

  // Window state and timer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Window next-state: a dropped enable abandons the partial window
  always_comb begin
    state_next   = state_reg;
    timer_next   = '0;
    clear_counts = 1'b0;
    collecting   = 1'b0;
    case (state_reg)
      IDLE: begin
        clear_counts = 1'b1;
        if (enable) state_next = COLLECT;
      end
      COLLECT: begin
        collecting = 1'b1;
        if (!enable) begin
          state_next = IDLE;
        end else if (timer_reg == TIMER_END) begin
          state_next = LATCH;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      LATCH: begin
        clear_counts = 1'b1;
        state_next   = enable ? COLLECT : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A LATCH can only snapshot if the frame in flight is idle or finishing now
  assign xfer      = busy_reg && rd.out_ready;
  assign last_xfer = xfer && (idx_reg == IDX_LAST);
  assign take_snap = (state_reg == LATCH) && (!busy_reg || last_xfer);
  assign drop_snap = (state_reg == LATCH) && busy_reg && !last_xfer;

  // Readout sequencer: a new snapshot restarts at bin 0, otherwise step on transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= 1'b0;
      idx_reg  <= '0;
    end else if (take_snap) begin
      busy_reg <= 1'b1;
      idx_reg  <= '0;
    end else if (last_xfer) begin
      busy_reg <= 1'b0;
      idx_reg  <= '0;
    end else if (xfer) begin
      idx_reg  <= idx_reg + 1'b1;
    end
  end

  // Sticky flag for a window whose data was lost to a busy readout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (drop_snap) begin
      overrun_reg <= 1'b1;
    end
  end

  // Snapshot registers, loaded in parallel so the consumer never sees live counts
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BINS; gi++) begin : g_snap
      // Capture bin gi at a snapshotting LATCH
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          snap_reg[gi] <= '0;
        end else if (take_snap) begin
          snap_reg[gi] <= bin_counts[gi*CNT_W +: CNT_W];
        end
      end
    end
  endgenerate

  assign overrun      = overrun_reg;
  assign rd.out_valid = busy_reg;
  assign rd.out_idx   = idx_reg;
  assign rd.out_data  = snap_reg[idx_reg];
  assign rd.out_last  = busy_reg && (idx_reg == IDX_LAST);

endmodule

// File: tb/tb_window_readout_ctrl.sv
// Directed bench for window_readout_ctrl with 10-cycle windows and 4 bins.
// Cycle numbers below count clock edges since reset release with enable=1.
module tb_window_readout_ctrl;

  localparam int NUM_BINS      = 4;
  localparam int CNT_W         = 16;
  localparam int WINDOW_CYCLES = 10;
  localparam int TIMER_W       = 4;

  logic                      clk;
  logic                      reset;
  logic                      enable;
  logic [NUM_BINS*CNT_W-1:0] bin_counts;
  logic                      clear_counts;
  logic                      collecting;
  logic                      overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  window_readout_ctrl_if #(.NUM_BINS(NUM_BINS), .CNT_W(CNT_W)) rd_if ();

  window_readout_ctrl #(
    .NUM_BINS      (NUM_BINS),
    .CNT_W         (CNT_W),
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .TIMER_W       (TIMER_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bin_counts   (bin_counts),
    .clear_counts (clear_counts),
    .collecting   (collecting),
    .overrun      (overrun),
    .rd           (rd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then read 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rd_if.out_ready = 1'b0; bin_counts = '0;
    repeat (3) tick();
    n_tests++; if (clear_counts !== 1'b1) begin n_fail++; $display("FAIL rst_clear got %b exp 1", clear_counts); end
    n_tests++; if (collecting !== 1'b0) begin n_fail++; $display("FAIL rst_collecting got %b exp 0", collecting); end
    n_tests++; if (rd_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", rd_if.out_valid); end
    n_tests++; if (rd_if.out_idx !== 2'd0) begin n_fail++; $display("FAIL rst_idx got %0d exp 0", rd_if.out_idx); end
    n_tests++; if (rd_if.out_data !== 16'd0) begin n_fail++; $display("FAIL rst_data got %0d exp 0", rd_if.out_data); end
    n_tests++; if (rd_if.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %b exp 0", rd_if.out_last); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    reset = 1'b0;
    enable = 1'b1;
    cyc = 0;
    n_tests++; if (clear_counts !== 1'b1) begin n_fail++; $display("FAIL idle_clear got %b exp 1", clear_counts); end
    $display("[TB] reset: outputs at reset values, released with enable=1");
  endtask

  task automatic test_window_timing();
    bin_counts = {16'd40, 16'd30, 16'd20, 16'd10};
    rd_if.out_ready = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_tests++; if (collecting !== (k <= 10)) begin n_fail++; $display("FAIL win_collecting cyc=%0d got %b exp %b", cyc, collecting, (k <= 10)); end
      n_tests++; if (clear_counts !== (k == 11)) begin n_fail++; $display("FAIL win_clear cyc=%0d got %b exp %b", cyc, clear_counts, (k == 11)); end
    end
    $display("[TB] window: 10 collecting cycles then LATCH at cycle %0d", cyc);
  endtask

  task automatic test_readout();
    int exp_data [4] = '{10, 20, 30, 40};
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) bin_counts = {16'd99, 16'd98, 16'd97, 16'd96};
      n_tests++; if (rd_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid cyc=%0d got %b exp 1", cyc, rd_if.out_valid); end
      n_tests++; if (rd_if.out_idx !== 2'(k)) begin n_fail++; $display("FAIL rd_idx cyc=%0d got %0d exp %0d", cyc, rd_if.out_idx, k); end
      n_tests++; if (rd_if.out_data !== 16'(exp_data[k])) begin n_fail++; $display("FAIL rd_data cyc=%0d got %0d exp %0d", cyc, rd_if.out_data, exp_data[k]); end
      n_tests++; if (rd_if.out_last !== (k == 3)) begin n_fail++; $display("FAIL rd_last cyc=%0d got %b exp %b", cyc, rd_if.out_last, (k == 3)); end
    end
    tick();
    n_tests++; if (rd_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_end_valid got %b exp 0", rd_if.out_valid); end
    n_tests++; if (rd_if.out_idx !== 2'd0) begin n_fail++; $display("FAIL rd_end_idx got %0d exp 0", rd_if.out_idx); end
    bin_counts = {16'd40, 16'd30, 16'd20, 16'd10};
    run_to(22);
    n_tests++; if (clear_counts !== 1'b1) begin n_fail++; $display("FAIL period_clear cyc=22 got %b exp 1", clear_counts); end
    n_tests++; if (collecting !== 1'b0) begin n_fail++; $display("FAIL period_collecting cyc=22 got %b exp 0", collecting); end
    $display("[TB] readout: frame 10,20,30,40 streamed, next LATCH at cycle %0d", cyc);
  endtask

  task automatic test_backpressure();
    tick();
    n_tests++; if (rd_if.out_data !== 16'd10) begin n_fail++; $display("FAIL bp_first_data got %0d exp 10", rd_if.out_data); end
    tick();
    rd_if.out_ready = 1'b0;
    bin_counts = {16'd8, 16'd7, 16'd6, 16'd5};
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (rd_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got %b exp 1", cyc, rd_if.out_valid); end
      n_tests++; if (rd_if.out_idx !== 2'd1) begin n_fail++; $display("FAIL bp_idx cyc=%0d got %0d exp 1", cyc, rd_if.out_idx); end
      n_tests++; if (rd_if.out_data !== 16'd20) begin n_fail++; $display("FAIL bp_data cyc=%0d got %0d exp 20", cyc, rd_if.out_data); end
      tick();
    end
    rd_if.out_ready = 1'b1;
    n_tests++; if (rd_if.out_idx !== 2'd1) begin n_fail++; $display("FAIL bp_hold_end_idx got %0d exp 1", rd_if.out_idx); end
    tick();
    n_tests++; if (rd_if.out_idx !== 2'd2 || rd_if.out_data !== 16'd30) begin n_fail++; $display("FAIL bp_resume idx/data got %0d/%0d exp 2/30", rd_if.out_idx, rd_if.out_data); end
    tick();
    n_tests++; if (rd_if.out_last !== 1'b1 || rd_if.out_data !== 16'd40) begin n_fail++; $display("FAIL bp_last last/data got %b/%0d exp 1/40", rd_if.out_last, rd_if.out_data); end
    tick();
    n_tests++; if (rd_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid got %b exp 0", rd_if.out_valid); end
    $display("[TB] backpressure: idx 1 held 5 cycles, frame completed at cycle %0d", cyc);
  endtask

  task automatic test_last_coincide();
    run_to(34);
    n_tests++; if (rd_if.out_idx !== 2'd0 || rd_if.out_data !== 16'd5) begin n_fail++; $display("FAIL co_first idx/data got %0d/%0d exp 0/5", rd_if.out_idx, rd_if.out_data); end
    rd_if.out_ready = 1'b0;
    bin_counts = {16'd1000, 16'd2000, 16'd3000, 16'd4000};
    run_to(41);
    rd_if.out_ready = 1'b1;
    run_to(44);
    n_tests++; if (rd_if.out_last !== 1'b1 || rd_if.out_data !== 16'd8) begin n_fail++; $display("FAIL co_last last/data got %b/%0d exp 1/8", rd_if.out_last, rd_if.out_data); end
    n_tests++; if (clear_counts !== 1'b1) begin n_fail++; $display("FAIL co_latch clear got %b exp 1", clear_counts); end
    tick();
    n_tests++; if (rd_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL co_new_valid got %b exp 1", rd_if.out_valid); end
    n_tests++; if (rd_if.out_idx !== 2'd0) begin n_fail++; $display("FAIL co_new_idx got %0d exp 0", rd_if.out_idx); end
    n_tests++; if (rd_if.out_data !== 16'd4000) begin n_fail++; $display("FAIL co_new_data got %0d exp 4000", rd_if.out_data); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL co_overrun got %b exp 0", overrun); end
    $display("[TB] coincide: last transfer on LATCH, new frame at cycle %0d without overrun", cyc);
  endtask

  task automatic test_overrun();
    rd_if.out_ready = 1'b0;
    bin_counts = {16'd9, 16'd9, 16'd9, 16'd9};
    run_to(55);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ov_before got %b exp 0", overrun); end
    tick();
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ov_set got %b exp 1", overrun); end
    n_tests++; if (rd_if.out_idx !== 2'd0 || rd_if.out_data !== 16'd4000) begin n_fail++; $display("FAIL ov_keep idx/data got %0d/%0d exp 0/4000", rd_if.out_idx, rd_if.out_data); end
    rd_if.out_ready = 1'b1;
    tick();
    n_tests++; if (rd_if.out_data !== 16'd3000) begin n_fail++; $display("FAIL ov_old1 got %0d exp 3000", rd_if.out_data); end
    tick();
    n_tests++; if (rd_if.out_data !== 16'd2000) begin n_fail++; $display("FAIL ov_old2 got %0d exp 2000", rd_if.out_data); end
    tick();
    n_tests++; if (rd_if.out_data !== 16'd1000 || rd_if.out_last !== 1'b1) begin n_fail++; $display("FAIL ov_old3 data/last got %0d/%b exp 1000/1", rd_if.out_data, rd_if.out_last); end
    tick();
    n_tests++; if (rd_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL ov_no_frame valid got %b exp 0", rd_if.out_valid); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ov_sticky got %b exp 1", overrun); end
    $display("[TB] overrun: LATCH during busy readout set overrun, old frame kept");
  endtask

  task automatic test_enable_drop();
    run_to(67);
    n_tests++; if (rd_if.out_valid !== 1'b1 || rd_if.out_data !== 16'd9) begin n_fail++; $display("FAIL en_frame valid/data got %b/%0d exp 1/9", rd_if.out_valid, rd_if.out_data); end
    run_to(72);
    enable = 1'b0;
    tick();
    n_tests++; if (clear_counts !== 1'b1 || collecting !== 1'b0) begin n_fail++; $display("FAIL en_idle clear/collecting got %b/%b exp 1/0", clear_counts, collecting); end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++; if (rd_if.out_valid !== 1'b0 || collecting !== 1'b0 || clear_counts !== 1'b1) begin n_fail++; $display("FAIL en_stay_idle cyc=%0d valid/collecting/clear got %b/%b/%b exp 0/0/1", cyc, rd_if.out_valid, collecting, clear_counts); end
    end
    $display("[TB] enable drop: idle from cycle 73, no LATCH or readout through cycle %0d", cyc);
  endtask

  task automatic test_enable_mid_readout();
    int exp_data [4] = '{11, 12, 13, 14};
    bin_counts = {16'd14, 16'd13, 16'd12, 16'd11};
    enable = 1'b1;
    run_to(104);
    n_tests++; if (clear_counts !== 1'b1) begin n_fail++; $display("FAIL mr_latch clear got %b exp 1", clear_counts); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) enable = 1'b0;
      n_tests++; if (rd_if.out_idx !== 2'(k) || rd_if.out_data !== 16'(exp_data[k])) begin n_fail++; $display("FAIL mr_word cyc=%0d idx/data got %0d/%0d exp %0d/%0d", cyc, rd_if.out_idx, rd_if.out_data, k, exp_data[k]); end
    end
    n_tests++; if (collecting !== 1'b0) begin n_fail++; $display("FAIL mr_collecting got %b exp 0", collecting); end
    tick();
    n_tests++; if (rd_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_done valid got %b exp 0", rd_if.out_valid); end
    $display("[TB] enable mid-readout: frame 11..14 completed with enable low");
  endtask

  task automatic test_reset_mid_frame();
    enable = 1'b1;
    rd_if.out_ready = 1'b0;
    run_to(121);
    n_tests++; if (rd_if.out_valid !== 1'b1 || rd_if.out_data !== 16'd11) begin n_fail++; $display("FAIL rm_frame valid/data got %b/%0d exp 1/11", rd_if.out_valid, rd_if.out_data); end
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (rd_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", rd_if.out_valid); end
    n_tests++; if (rd_if.out_data !== 16'd0) begin n_fail++; $display("FAIL rm_data got %0d exp 0", rd_if.out_data); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rm_overrun got %b exp 0", overrun); end
    n_tests++; if (clear_counts !== 1'b1 || collecting !== 1'b0) begin n_fail++; $display("FAIL rm_state clear/collecting got %b/%b exp 1/0", clear_counts, collecting); end
    tick();
    reset = 1'b0;
    $display("[TB] reset mid-frame: readout abandoned without a clock edge");
  endtask

  initial begin
    test_reset();
    test_window_timing();
    test_readout();
    test_backpressure();
    test_last_coincide();
    test_overrun();
    test_enable_drop();
    test_enable_mid_readout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
